// File: rtl/uart_rx_if.sv
// Receiver-side UART bus: serial line in, deserialised byte and status out.
// master is the receiver, slave is the line driver / byte consumer.
interface uart_rx_if;
    logic       rxd;
    logic [7:0] data_i;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        output data_i,
        output data_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rxd,
        input  data_i,
        input  data_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, CLKS_PER_BIT clocks per bit.
// Define UART_RX_SYNC_EN to put a 2-flop synchroniser in front of rxd.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_H    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic rxd_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.rxd};
    end

    assign rxd_s = sync_q[1];
`else
    assign rxd_s = bus.rxd;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             armed_q, armed_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    logic             sample;
    logic             last;
    logic [CNT_W-1:0] cnt_inc;

    // Next-state: cnt tracks position inside the current bit, sampling at its middle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        armed_d = armed_q | rxd_s;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        sample  = (cnt_q == CNT_H);
        last    = (cnt_q == CNT_LAST);
        cnt_inc = last ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (armed_q && !rxd_s) begin
                    idx_d = '0;
                    // With one clock per bit the start sample is this cycle
                    if (CLKS_PER_BIT == 1) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            START: begin
                cnt_d = cnt_inc;
                if (sample && rxd_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_inc;
                if (sample) shift_d = {rxd_s, shift_q[7:1]};
                if (last) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                cnt_d = cnt_inc;
                if (sample) par_d = rxd_s;
                if (last) state_d = STOP;
            end
            STOP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (sample) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = par_q ^ (^shift_q);
                    ferr_d  = ~rxd_s;
                    if (!rxd_s) armed_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.data_i     = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one receiver at 1 clock/bit, one at 16 clocks/bit,
// pulses logged with their cycle number and compared against a frame-level model.
module tb_uart_rx;
    logic clk;
    logic rst;
    logic rxd1;
    logic rxd16;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_rx_if if1 ();
    uart_rx_if if16 ();

    assign if1.rxd  = rxd1;
    assign if16.rxd = rxd16;

    uart_rx #(.CLKS_PER_BIT(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    uart_rx #(.CLKS_PER_BIT(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    rec_t q1[$];
    rec_t q16[$];

    // Log every valid pulse with the cycle it is visible in
    always @(negedge clk) begin
        if (if1.data_valid === 1'b1)  q1.push_back('{cyc, if1.data_i, if1.parity_err, if1.frame_err});
        if (if16.data_valid === 1'b1) q16.push_back('{cyc, if16.data_i, if16.parity_err, if16.frame_err});
    end

    // Expected report for a frame whose start bit is first seen in cycle t0
    function automatic rec_t model(input int n, input int t0, input logic [7:0] d,
                                   input logic par, input logic stop);
        rec_t r;
        r.t  = t0 + 10 * n + (n - 1) / 2 + 1;
        r.d  = d;
        r.pe = par ^ (^d);
        r.fe = ~stop;
        return r;
    endfunction

    function automatic string fmt(input rec_t r);
        return $sformatf("t=%0d d=%02h pe=%b fe=%b", r.t, r.d, r.pe, r.fe);
    endfunction

    task automatic set_line(input int n, input logic v);
        if (n == 1) rxd1 = v;
        else        rxd16 = v;
    endtask

    task automatic hold(input int n, input logic v, input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            set_line(n, v);
        end
    endtask

    // Drive up to 'limit' bit-cycles of a frame; t0 = cycle carrying the first start cycle
    task automatic drive_frame(input int n, input logic [7:0] d, input logic par,
                               input logic stop, input int limit,
                               output int t0, output logic busy1);
        logic [10:0] bits;
        int idx;
        bits  = {stop, par, d, 1'b0};
        idx   = 0;
        t0    = 0;
        busy1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            for (int j = 0; j < n; j++) begin
                if (idx < limit) begin
                    @(negedge clk);
                    if (idx == 0) t0 = cyc;
                    if (idx == 1) busy1 = (n == 1) ? if1.busy : if16.busy;
                    set_line(n, bits[k]);
                    idx++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        rxd1  = 1'b1;
        rxd16 = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({if1.data_i, if1.data_valid, if1.parity_err, if1.frame_err, if1.busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_n1 got %h need 000",
                     {if1.data_i, if1.data_valid, if1.parity_err, if1.frame_err, if1.busy});
        end
        checks++;
        if ({if16.data_i, if16.data_valid, if16.parity_err, if16.frame_err, if16.busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_n16 got %h need 000",
                     {if16.data_i, if16.data_valid, if16.parity_err, if16.frame_err, if16.busy});
        end
        rst = 1'b0;
        hold(1, 1'b1, 3);
        q1.delete();
        q16.delete();
    endtask

    task automatic test_basic;
        int t0;
        logic b1;
        rec_t e, g;
        drive_frame(1, 8'hA5, 1'b0, 1'b1, 11, t0, b1);
        hold(1, 1'b1, 14);
        e = model(1, t0, 8'hA5, 1'b0, 1'b1);
        checks++;
        if (b1 !== 1'b1) begin errors++; $display("FAIL basic_busy got %b need 1", b1); end
        checks++;
        if (if1.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b need 0", if1.busy); end
        checks++;
        if (q1.size() != 1) begin
            errors++;
            $display("FAIL basic_count got %0d need 1", q1.size());
        end else begin
            g = q1.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL basic_frame got %s need %s", fmt(g), fmt(e));
            end
        end
        q1.delete();
    endtask

    task automatic test_back_to_back;
        int ta, tb;
        logic b1;
        rec_t e[2];
        rec_t g;
        drive_frame(1, 8'h01, 1'b1, 1'b1, 11, ta, b1);
        drive_frame(1, 8'hFF, 1'b0, 1'b1, 11, tb, b1);
        hold(1, 1'b1, 14);
        e[0] = model(1, ta, 8'h01, 1'b1, 1'b1);
        e[1] = model(1, tb, 8'hFF, 1'b0, 1'b1);
        checks++;
        if (tb - ta != 11) begin errors++; $display("FAIL b2b_spacing got %0d need 11", tb - ta); end
        checks++;
        if (q1.size() != 2) begin
            errors++;
            $display("FAIL b2b_count got %0d need 2", q1.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                g = q1.pop_front();
                checks++;
                if (g.t !== e[i].t || g.d !== e[i].d || g.pe !== e[i].pe || g.fe !== e[i].fe) begin
                    errors++;
                    $display("FAIL b2b_frame%0d got %s need %s", i, fmt(g), fmt(e[i]));
                end
            end
        end
        q1.delete();
    endtask

    task automatic test_parity;
        int t0;
        logic b1;
        rec_t e, g;
        drive_frame(16, 8'h3C, 1'b1, 1'b1, 176, t0, b1);
        hold(16, 1'b1, 20);
        e = model(16, t0, 8'h3C, 1'b1, 1'b1);
        checks++;
        if (q16.size() != 1) begin
            errors++;
            $display("FAIL parity_count got %0d need 1", q16.size());
        end else begin
            g = q16.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL parity_frame got %s need %s", fmt(g), fmt(e));
            end
        end
        q16.delete();
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rxd16 = 1'b0;
        @(negedge clk);
        checks++;
        if (if16.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_t1 got %b need 1", if16.busy); end
        rxd16 = 1'b0;
        @(negedge clk);
        rxd16 = 1'b0;
        @(negedge clk);
        rxd16 = 1'b1;
        hold(16, 1'b1, 5);
        checks++;
        if (if16.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_t8 got %b need 0", if16.busy); end
        hold(16, 1'b1, 200);
        checks++;
        if (q16.size() != 0) begin errors++; $display("FAIL glitch_pulse got %0d need 0", q16.size()); end
        checks++;
        if (if16.data_i !== 8'h3C) begin errors++; $display("FAIL glitch_data got %02h need 3c", if16.data_i); end
        q16.delete();
    endtask

    task automatic test_frame_err;
        int t0;
        logic b1;
        rec_t e, g;
        drive_frame(1, 8'h55, 1'b0, 1'b0, 11, t0, b1);
        hold(1, 1'b0, 20);
        e = model(1, t0, 8'h55, 1'b0, 1'b0);
        checks++;
        if (q1.size() != 1) begin
            errors++;
            $display("FAIL ferr_count got %0d need 1", q1.size());
        end else begin
            g = q1.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL ferr_frame got %s need %s", fmt(g), fmt(e));
            end
        end
        checks++;
        if (if1.busy !== 1'b0) begin errors++; $display("FAIL ferr_disarm got %b need 0", if1.busy); end
        q1.delete();
        hold(1, 1'b1, 3);
        drive_frame(1, 8'h0F, 1'b0, 1'b1, 11, t0, b1);
        hold(1, 1'b1, 14);
        e = model(1, t0, 8'h0F, 1'b0, 1'b1);
        checks++;
        if (q1.size() != 1) begin
            errors++;
            $display("FAIL ferr_recover_count got %0d need 1", q1.size());
        end else begin
            g = q1.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL ferr_recover_frame got %s need %s", fmt(g), fmt(e));
            end
        end
        q1.delete();
    endtask

    task automatic test_reset_mid;
        int t0;
        logic b1;
        rec_t e, g;
        // Stop in the middle of data bit 4 (bit slot 5)
        drive_frame(16, 8'hC3, 1'b0, 1'b1, 5 * 16 + 8, t0, b1);
        checks++;
        if (if16.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b need 1", if16.busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({if16.data_i, if16.data_valid, if16.parity_err, if16.frame_err, if16.busy} !== 12'h000) begin
            errors++;
            $display("FAIL rstmid_outputs got %h need 000",
                     {if16.data_i, if16.data_valid, if16.parity_err, if16.frame_err, if16.busy});
        end
        rst   = 1'b0;
        rxd16 = 1'b1;
        hold(16, 1'b1, 200);
        checks++;
        if (q16.size() != 0) begin errors++; $display("FAIL rstmid_pulse got %0d need 0", q16.size()); end
        q16.delete();
        drive_frame(16, 8'h96, 1'b0, 1'b1, 176, t0, b1);
        hold(16, 1'b1, 20);
        e = model(16, t0, 8'h96, 1'b0, 1'b1);
        checks++;
        if (q16.size() != 1) begin
            errors++;
            $display("FAIL rstmid_next_count got %0d need 1", q16.size());
        end else begin
            g = q16.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL rstmid_next_frame got %s need %s", fmt(g), fmt(e));
            end
        end
        q16.delete();
    endtask

    // Random bytes, parity faults, stop faults and idle gaps
    task automatic test_random(input int n, input int frames);
        rec_t exp_q[$];
        rec_t g, e;
        int t0, gap, got_n;
        logic b1, par, stop;
        logic [7:0] d;
        if (n == 1) q1.delete();
        else        q16.delete();
        for (int i = 0; i < frames; i++) begin
            d    = 8'($urandom);
            par  = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
            drive_frame(n, d, par, stop, 11 * n, t0, b1);
            exp_q.push_back(model(n, t0, d, par, stop));
            hold(n, 1'b1, gap);
        end
        hold(n, 1'b1, 12 * n + 4);
        got_n = (n == 1) ? q1.size() : q16.size();
        checks++;
        if (got_n != exp_q.size()) begin
            errors++;
            $display("FAIL rand_n%0d_count got %0d need %0d", n, got_n, exp_q.size());
        end
        while (exp_q.size() > 0 && ((n == 1) ? q1.size() : q16.size()) > 0) begin
            e = exp_q.pop_front();
            g = (n == 1) ? q1.pop_front() : q16.pop_front();
            checks++;
            if (g.t !== e.t || g.d !== e.d || g.pe !== e.pe || g.fe !== e.fe) begin
                errors++;
                $display("FAIL rand_n%0d_frame got %s need %s", n, fmt(g), fmt(e));
            end
        end
        q1.delete();
        q16.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_random(1, 40);
        test_random(16, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the team's UART link: start bit (0), 8 data bits LSB first, even-parity bit, one stop bit (1). Deserialises `rxd` into a byte and reports parity and framing errors. Sits at the far end of the line driven by the team's UART transmitter and hands each received byte to downstream logic with a single-cycle valid pulse. Bit period is a parameter; `CLKS_PER_BIT=1` pairs directly with the one-bit-per-clock transmitter.

## Interface
- `CLKS_PER_BIT`, default 1: clocks per serial bit (N). Legal range is 1..65535.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. Clock is `clk`.
- `rxd` in 1: serial line. Idles high.
- `data_i` out 8: last received byte.
- `data_valid` out 1: one-cycle pulse per completed frame.
- `parity_err` out 1: parity mismatch on the last frame.
- `frame_err` out 1: stop bit sampled low on the last frame.
- `busy` out 1: receiver is inside a frame.

## Operation
- `rxd_s` is the line as seen by the FSM (see Configuration).
- H = (N-1)/2, integer division.
- States: IDLE, START, DATA, PARITY, STOP. A bit counter (0..N-1) and a data index (0..7) drive transitions.
- Arming: IDLE accepts a start only when armed. The receiver is armed after `rxd_s`==1 has been seen for at least one cycle since reset or since the last frame error.
- Start detection: T0 is the first cycle in IDLE, armed, with `rxd_s`==0. Bit k occupies cycles T0+kN..T0+kN+N-1:
  - k=0: start.
  - k=1..8: data[0..7].
  - k=9: parity.
  - k=10: stop.
- Each bit is sampled once, at T0+kN+H.
- False start: start sample reads 1 → return to IDLE. No outputs change. With N=1 the start sample is T0 itself.
- Data bits shift into an internal register LSB first.
- Parity check: `parity_err` = parity sample XOR (^data). Computed fresh each frame.
- Frame check: `frame_err` = NOT stop sample. A frame error also disarms the receiver.
- Frame completion:
  - At the cycle after the stop sample, `data_valid`=1 for exactly one cycle.
  - `data_i`, `parity_err` and `frame_err` update in that same cycle and hold until the next `data_valid`.
  - Bad frames still pulse `data_valid`, and `data_i` carries the sampled bits.
- After the stop sample the FSM is in IDLE on the next cycle. Back-to-back frames with no idle gap are accepted.
- `busy`=1 from T0+1 through the stop-sample cycle, 0 otherwise.
- Reset values: `data_i`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, FSM=IDLE, armed=0.
- Reset mid-frame: the frame is discarded, no `data_valid` is produced, and outputs return to reset values the cycle after `rst` is sampled high.
- `rxd` changes between sample points are ignored. There is no glitch filtering beyond the single sample per bit.

## Timing
- Latency from T0 to `data_valid`: 10N+H+1 cycles, measured on `rxd_s`.
  - N=1: `data_valid` at T0+11.
  - N=16: `data_valid` at T0+168.
- Minimum frame spacing: 11N cycles; the next T0 can be T0+11N.
- All outputs are registered. There are no combinational paths from `rxd` to outputs.
- `data_valid` has no back-pressure. Downstream logic must capture the byte in the pulse cycle.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rxd` passes through a 2-flop synchroniser, both flops reset to 1, to form `rxd_s`.
  - All latencies measured from `rxd` grow by 2 cycles; N=1 gives `data_valid` 13 cycles after the start bit appears on `rxd`.
- `UART_RX_SYNC_EN` undefined: `rxd_s`=`rxd` directly. Used for same-clock-domain loopback with the transmitter.

## Test plan
- N=1, no sync, after reset and idle high: drive start, then 0xA5 LSB first, then parity 0, then stop 1. Expect `data_valid` at T0+11 with `data_i`=0xA5, `parity_err`=0, `frame_err`=0.
- N=1: send two back-to-back frames 0x01 (parity 1) then 0xFF (parity 0) with no gap. Expect two pulses 11 cycles apart, carrying 0x01 then 0xFF, with no errors.
- N=16: send 0x3C with parity forced to 1. Expect `data_valid` at T0+168 with `data_i`=0x3C and `parity_err`=1.
- N=16: drive a 3-cycle low glitch in idle. Expect no `data_valid` and `busy` back to 0 by T0+8.
- N=1: send 0x55 with stop bit 0 and hold the line low. Expect a pulse with `frame_err`=1 and no new frame until the line returns high, after which a frame of 0x0F is received cleanly.
- N=16: assert `rst` during data bit 4. Expect outputs at reset values next cycle, no pulse, and correct reception of the next full frame.
